age_priority_select_pipe: RTL and testbench
===========================================

# age_priority_select_pipe

Pipelined, parametrised age-order selector for circular queues in the out-of-order LSU. It picks up to NUM_SELECT valid entries in age order relative to a head pointer, either oldest-first or youngest-first, and can bound the search to entries older than a limit index. Results are registered behind a single-entry valid/ready stage. It is the multi-grant, windowed, registered successor to the single combinational youngest-entry picker, for store-to-load forwarding searches and multi-issue load/store wakeup.

## Interface
- DEPTH, 32, queue entries; power of two, at least 2
- NUM_SELECT, 2, grants per request; 1 to DEPTH
- TAG_WIDTH, 6, opaque requester tag carried through unchanged
- IDX_W, $clog2(DEPTH), derived index width; not overridable
- clk  input  1  single clock; all state on posedge
- reset_n  input  1  synchronous, active-low reset
- flush  input  1  discards the held result and any same-cycle request
- in_valid  input  1  request present
- in_ready  output  1  stage can accept: !out_valid | out_ready
- in_valid_bits  input  DEPTH  per-entry candidate bits
- in_head_index  input  IDX_W  physical index of the oldest entry
- in_mode  input  1  select_mode_e: 0 = OLDEST_FIRST, 1 = YOUNGEST_FIRST
- in_limit_enable  input  1  restricts the window to entries older than in_limit_index
- in_limit_index  input  IDX_W  exclusive window bound, physical index
- in_tag  input  TAG_WIDTH  requester tag
- out_valid  output  1  result held
- out_ready  input  1  consumer takes the result
- out_index  output  NUM_SELECT*IDX_W  slot k in bits [k*IDX_W +: IDX_W]; slot 0 is the highest priority
- out_index_valid  output  NUM_SELECT  slot k holds a grant
- out_any  output  1  at least one candidate was in the window
- out_count  output  $clog2(NUM_SELECT+1)  number of grants issued, min(candidates, NUM_SELECT)
- out_tag  output  TAG_WIDTH  tag captured with the request

## Operation
- Relative age of entry i: rel(i) = (i - in_head_index) mod DEPTH, in IDX_W-bit wraparound arithmetic. rel 0 is the oldest entry.
- Window:
  - in_limit_enable = 0: every entry is in the window.
  - in_limit_enable = 1: entry i is in the window iff rel(i) < (in_limit_index - in_head_index) mod DEPTH.
  - in_limit_index == in_head_index with the limit enabled gives an empty window.
- Candidate set = in_valid_bits AND window.
- OLDEST_FIRST: slot k receives the candidate with the (k+1)-th smallest rel.
- YOUNGEST_FIRST: slot k receives the candidate with the (k+1)-th largest rel.
- Ungranted slots: out_index_valid[k] = 0 and out_index slot = 0.
- Granted slots are contiguous from slot 0. Indices in out_index are physical.
- out_any = OR of the candidate set. It does not include entries outside the window.
- Capture happens when in_valid & in_ready & !flush. On capture, all result fields, out_tag and out_valid = 1 register together.
- out_valid clears on out_ready with no new capture. A result is held stable while out_valid & !out_ready.
- Grant selection must be iterative masking: find the first candidate, clear it, repeat NUM_SELECT times, on the rotated vector. Rotate back with the rotator sub-module.

## Timing
- Reset (reset_n low at posedge) clears out_valid, out_index, out_index_valid, out_any, out_count and out_tag to 0. in_ready then reads 1.
- Latency: 1 cycle, from the capturing edge to out_valid.
- Throughput: one request per cycle while out_ready is held high. in_ready depends combinationally on out_ready.
- flush at an edge sets out_valid to 0 next cycle, whether or not out_ready is high. A request presented in the same cycle is dropped, not captured.
- Reset asserted mid-transfer aborts the result; nothing is re-presented afterwards.
- Inputs are sampled only at the capture edge. Changes to in_* while the stage is stalled have no effect on the held result.

## Structure
- Shared package lsu_pkg holds the select_mode_e enum (OLDEST_FIRST = 1'b0, YOUNGEST_FIRST = 1'b1).
- One sub-module, circular_rotate #(WIDTH, DIR): a barrel rotate by a runtime amount, left or right.
  - Instantiated once to rotate the candidates to head-at-0.
  - Instantiated NUM_SELECT times to rotate the one-hot grants back, or the grants are converted to indices by adding in_head_index mod DEPTH. The latter is preferred.
- Priority, window, and grant logic are combinational before the single output register stage.

## Test plan
- Wraparound: DEPTH=8, NUM_SELECT=2, head=6, valid=8'b1100_0101, OLDEST_FIRST, no limit. Expect slots {6,7}, count=2, out_any=1 one cycle after capture. Same input with YOUNGEST_FIRST: expect {2,0}.
- Limit window: DEPTH=8, head=6, limit=1, valid=8'b1111_1111, YOUNGEST_FIRST. Expect window {6,7,0}, slots {0,7}. With limit=6 (== head): out_any=0, count=0, out_index_valid=00.
- Partial grant: DEPTH=32, NUM_SELECT=4, head=0, only bit 31 set, OLDEST_FIRST. Expect slot0=31, out_index_valid=4'b0001, count=1, other slot indices 0.
- Backpressure: capture request A, then hold out_ready=0 for 3 cycles while driving request B. Expect in_ready=0, A's fields and tag stable. Raise out_ready: A taken, B captured on the same edge, B valid the next cycle.
- Flush: flush together with in_valid=1 while a result is held. Next cycle out_valid=0 and nothing from the flushed-cycle request is ever seen.
- Reset: reset_n low with out_valid=1. Next cycle all outputs 0 and in_ready=1. Randomised back-to-back traffic is checked against a sorted-by-rel reference model.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared LSU types: selection order and rotate direction.
// Imported by the age selector, its interface and the rotator.
package lsu_pkg;

  typedef enum logic {
    OLDEST_FIRST   = 1'b0,
    YOUNGEST_FIRST = 1'b1
  } select_mode_e;

  localparam bit ROT_RIGHT = 1'b0;
  localparam bit ROT_LEFT  = 1'b1;

endpackage

// File: rtl/age_priority_select_pipe_if.sv
// Request/result bundle of the age selector.
// master drives in_* and out_ready; slave drives in_ready and out_*.
interface age_priority_select_pipe_if
  import lsu_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int NUM_SELECT = 2,
  parameter int TAG_WIDTH  = 6
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_SELECT + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [DEPTH-1:0]            in_valid_bits;
  logic [IDX_W-1:0]            in_head_index;
  select_mode_e                in_mode;
  logic                        in_limit_enable;
  logic [IDX_W-1:0]            in_limit_index;
  logic [TAG_WIDTH-1:0]        in_tag;

  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_SELECT*IDX_W-1:0] out_index;
  logic [NUM_SELECT-1:0]       out_index_valid;
  logic                        out_any;
  logic [CNT_W-1:0]            out_count;
  logic [TAG_WIDTH-1:0]        out_tag;

  modport master (
    output in_valid, in_valid_bits,
    output in_head_index, in_mode,
    output in_limit_enable,
    output in_limit_index, in_tag,
    output out_ready,
    input  in_ready, out_valid,
    input  out_index, out_index_valid,
    input  out_any, out_count, out_tag
  );

  modport slave (
    input  in_valid, in_valid_bits,
    input  in_head_index, in_mode,
    input  in_limit_enable,
    input  in_limit_index, in_tag,
    input  out_ready,
    output in_ready, out_valid,
    output out_index, out_index_valid,
    output out_any, out_count, out_tag
  );

endinterface

// File: rtl/circular_rotate.sv
// Barrel rotate of WIDTH bits by a runtime amount.
// Ports: data_i, amt_i (log2 WIDTH bits), data_o; DIR picks right/left.
module circular_rotate
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit DIR   = ROT_RIGHT
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] amt_i,
  output logic [WIDTH-1:0]         data_o
);
  localparam int AW = $clog2(WIDTH);

  // WIDTH is a power of two, so AW-bit
  // index arithmetic wraps for free.
  always_comb begin
    data_o = '0;
    for (int r = 0; r < WIDTH; r++) begin
      if (DIR == ROT_RIGHT)
        data_o[r] = data_i[AW'(r) + amt_i];
      else
        data_o[r] = data_i[AW'(r) - amt_i];
    end
  end

endmodule

// File: rtl/age_priority_select_pipe.sv
// Multi-grant age-order selector over a circular queue, one reg stage.
// Ports: clk, reset_n (sync, low), flush, bus (slave request/result).
module age_priority_select_pipe
  import lsu_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int NUM_SELECT = 2,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  age_priority_select_pipe_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(NUM_SELECT + 1);
  localparam int OW    = NUM_SELECT * IDX_W;

  logic [DEPTH-1:0]      rot;
  logic [DEPTH-1:0]      win;
  logic [DEPTH-1:0]      cand;
  logic [DEPTH-1:0]      vec;
  logic [IDX_W-1:0]      lim_rel;
  logic [IDX_W-1:0]      pos;
  logic [IDX_W-1:0]      rel;
  logic                  found;
  logic                  young;
  logic                  cap;

  logic                  valid_q;
  logic [OW-1:0]         idx_d, idx_q;
  logic [NUM_SELECT-1:0] ivld_d, ivld_q;
  logic                  any_d, any_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;
  logic [TAG_WIDTH-1:0]  tag_q;

  // Bit r of rot is the entry with rel age r.
  circular_rotate #(
    .WIDTH (DEPTH),
    .DIR   (ROT_RIGHT)
  ) u_rot (
    .data_i (bus.in_valid_bits),
    .amt_i  (bus.in_head_index),
    .data_o (rot)
  );

  assign young = (bus.in_mode == YOUNGEST_FIRST);

  always_comb begin
    lim_rel = bus.in_limit_index
            - bus.in_head_index;
    win = '0;
    for (int r = 0; r < DEPTH; r++)
      win[r] = !bus.in_limit_enable ||
               (IDX_W'(r) < lim_rel);
    cand  = rot & win;
    any_d = |cand;
  end

  // Youngest-first scans a bit-reversed
  // vector; position p maps to rel ~p.
  always_comb begin
    vec    = '0;
    idx_d  = '0;
    ivld_d = '0;
    cnt_d  = '0;
    found  = 1'b0;
    pos    = '0;
    rel    = '0;
    for (int i = 0; i < DEPTH; i++)
      vec[i] = young ? cand[DEPTH-1-i]
                     : cand[i];
    for (int k = 0; k < NUM_SELECT; k++) begin
      found = 1'b0;
      pos   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && vec[i]) begin
          found = 1'b1;
          pos   = IDX_W'(i);
        end
      end
      if (found) begin
        vec[pos] = 1'b0;
        rel = young ? ~pos : pos;
        idx_d[k*IDX_W +: IDX_W] =
          rel + bus.in_head_index;
        ivld_d[k] = 1'b1;
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign cap = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      ivld_q  <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (cap)
        valid_q <= 1'b1;
      else if (bus.out_ready)
        valid_q <= 1'b0;
      if (cap) begin
        idx_q  <= idx_d;
        ivld_q <= ivld_d;
        any_q  <= any_d;
        cnt_q  <= cnt_d;
        tag_q  <= bus.in_tag;
      end
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_index       = idx_q;
  assign bus.out_index_valid = ivld_q;
  assign bus.out_any         = any_q;
  assign bus.out_count       = cnt_q;
  assign bus.out_tag         = tag_q;

endmodule

// File: tb/tb_age_priority_select_pipe.sv
// Directed bench for age_priority_select_pipe.
// Two instances: DEPTH=8/NS=2 and DEPTH=32/NS=4.
module tb_age_priority_select_pipe;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  age_priority_select_pipe_if #(
    .DEPTH(8), .NUM_SELECT(2), .TAG_WIDTH(6)
  ) b8 ();

  age_priority_select_pipe_if #(
    .DEPTH(32), .NUM_SELECT(4), .TAG_WIDTH(6)
  ) b32 ();

  age_priority_select_pipe #(
    .DEPTH(8), .NUM_SELECT(2), .TAG_WIDTH(6)
  ) u8 (
    .clk(clk), .reset_n(reset_n),
    .flush(flush), .bus(b8)
  );

  age_priority_select_pipe #(
    .DEPTH(32), .NUM_SELECT(4), .TAG_WIDTH(6)
  ) u32 (
    .clk(clk), .reset_n(reset_n),
    .flush(flush), .bus(b32)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h exp %0h",
                  tag, got, exp);
  endtask

  task automatic drv8(
    input logic         v,
    input logic [7:0]   bits,
    input logic [2:0]   head,
    input select_mode_e m,
    input logic         len,
    input logic [2:0]   lim,
    input logic [5:0]   tag
  );
    b8.in_valid        = v;
    b8.in_valid_bits   = bits;
    b8.in_head_index   = head;
    b8.in_mode         = m;
    b8.in_limit_enable = len;
    b8.in_limit_index  = lim;
    b8.in_tag          = tag;
  endtask

  task automatic res8(
    input string       nm,
    input logic [5:0]  idx,
    input logic [1:0]  iv,
    input logic        any,
    input logic [1:0]  cnt,
    input logic [5:0]  tag
  );
    chk({nm, ".valid"}, 64'(b8.out_valid), 64'd1);
    chk({nm, ".index"}, 64'(b8.out_index), 64'(idx));
    chk({nm, ".ivld"},
        64'(b8.out_index_valid), 64'(iv));
    chk({nm, ".any"}, 64'(b8.out_any), 64'(any));
    chk({nm, ".count"}, 64'(b8.out_count), 64'(cnt));
    chk({nm, ".tag"}, 64'(b8.out_tag), 64'(tag));
  endtask

  task automatic zero8(input string nm);
    chk({nm, ".valid"}, 64'(b8.out_valid), 64'd0);
    chk({nm, ".index"}, 64'(b8.out_index), 64'd0);
    chk({nm, ".ivld"},
        64'(b8.out_index_valid), 64'd0);
    chk({nm, ".any"}, 64'(b8.out_any), 64'd0);
    chk({nm, ".count"}, 64'(b8.out_count), 64'd0);
    chk({nm, ".tag"}, 64'(b8.out_tag), 64'd0);
    chk({nm, ".rdy"}, 64'(b8.in_ready), 64'd1);
  endtask

  initial begin
    drv8(1'b0, 8'h00, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd0);
    b8.out_ready         = 1'b1;
    b32.in_valid         = 1'b0;
    b32.in_valid_bits    = '0;
    b32.in_head_index    = '0;
    b32.in_mode          = OLDEST_FIRST;
    b32.in_limit_enable  = 1'b0;
    b32.in_limit_index   = '0;
    b32.in_tag           = '0;
    b32.out_ready        = 1'b1;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    zero8("rst");
    chk("rst32.valid", 64'(b32.out_valid), 64'd0);

    // wraparound, oldest then youngest
    drv8(1'b1, 8'b1100_0101, 3'd6, OLDEST_FIRST,
         1'b0, 3'd0, 6'd5);
    @(negedge clk);
    res8("wrap_old", {3'd7, 3'd6}, 2'b11,
         1'b1, 2'd2, 6'd5);
    drv8(1'b1, 8'b1100_0101, 3'd6, YOUNGEST_FIRST,
         1'b0, 3'd0, 6'd6);
    @(negedge clk);
    res8("wrap_yng", {3'd0, 3'd2}, 2'b11,
         1'b1, 2'd2, 6'd6);

    // limit window {6,7,0}
    drv8(1'b1, 8'hFF, 3'd6, YOUNGEST_FIRST,
         1'b1, 3'd1, 6'd7);
    @(negedge clk);
    res8("lim", {3'd7, 3'd0}, 2'b11,
         1'b1, 2'd2, 6'd7);
    // limit == head: empty window
    drv8(1'b1, 8'hFF, 3'd6, YOUNGEST_FIRST,
         1'b1, 3'd6, 6'd8);
    @(negedge clk);
    res8("lim_empty", 6'd0, 2'b00,
         1'b0, 2'd0, 6'd8);
    // entry just inside / just outside bound
    drv8(1'b1, 8'b0000_1000, 3'd2, OLDEST_FIRST,
         1'b1, 3'd5, 6'd9);
    @(negedge clk);
    res8("lim_in", {3'd0, 3'd3}, 2'b01,
         1'b1, 2'd1, 6'd9);
    drv8(1'b1, 8'b0010_0000, 3'd2, OLDEST_FIRST,
         1'b1, 3'd5, 6'd10);
    @(negedge clk);
    res8("lim_out", 6'd0, 2'b00,
         1'b0, 2'd0, 6'd10);
    b8.in_valid = 1'b0;
    @(negedge clk);
    chk("drain.valid", 64'(b8.out_valid), 64'd0);

    // DEPTH=32 partial grant
    b32.in_valid      = 1'b1;
    b32.in_valid_bits = 32'h8000_0000;
    b32.in_head_index = 5'd0;
    b32.in_tag        = 6'd21;
    @(negedge clk);
    chk("part.index", 64'(b32.out_index), 64'd31);
    chk("part.ivld",
        64'(b32.out_index_valid), 64'b0001);
    chk("part.count", 64'(b32.out_count), 64'd1);
    chk("part.tag", 64'(b32.out_tag), 64'd21);
    // four grants across the wrap
    b32.in_valid_bits = 32'hC000_0023;
    b32.in_head_index = 5'd30;
    b32.in_tag        = 6'd22;
    @(negedge clk);
    chk("wrap4.index", 64'(b32.out_index),
        64'({5'd1, 5'd0, 5'd31, 5'd30}));
    chk("wrap4.ivld",
        64'(b32.out_index_valid), 64'b1111);
    chk("wrap4.count", 64'(b32.out_count), 64'd4);
    b32.in_valid = 1'b0;
    @(negedge clk);
    chk("drain32", 64'(b32.out_valid), 64'd0);

    // backpressure: A held, B waits
    drv8(1'b1, 8'b0000_0011, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd10);
    b8.out_ready = 1'b0;
    @(negedge clk);
    drv8(1'b1, 8'b1000_0000, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd11);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.rdy", 64'(b8.in_ready), 64'd0);
      res8("bp.A", {3'd1, 3'd0}, 2'b11,
           1'b1, 2'd2, 6'd10);
      @(negedge clk);
    end
    b8.out_ready = 1'b1;
    #1;
    chk("bp.rdy_hi", 64'(b8.in_ready), 64'd1);
    @(negedge clk);
    res8("bp.B", {3'd0, 3'd7}, 2'b01,
         1'b1, 2'd1, 6'd11);
    b8.in_valid = 1'b0;
    @(negedge clk);
    chk("bp.drain", 64'(b8.out_valid), 64'd0);

    // flush with a same-cycle request
    drv8(1'b1, 8'h0F, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd12);
    b8.out_ready = 1'b0;
    @(negedge clk);
    chk("fl.held", 64'(b8.out_tag), 64'd12);
    drv8(1'b1, 8'hF0, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd13);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    b8.in_valid = 1'b0;
    chk("fl.valid", 64'(b8.out_valid), 64'd0);
    b8.out_ready = 1'b1;
    @(negedge clk);
    chk("fl.valid2", 64'(b8.out_valid), 64'd0);
    chk("fl.tag_not13",
        64'(b8.out_tag == 6'd13), 64'd0);

    // reset while a result is held
    drv8(1'b1, 8'h81, 3'd0, OLDEST_FIRST,
         1'b0, 3'd0, 6'd14);
    b8.out_ready = 1'b0;
    @(negedge clk);
    chk("mr.held", 64'(b8.out_valid), 64'd1);
    b8.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    zero8("mr");
    reset_n = 1'b1;
    b8.out_ready = 1'b1;
    @(negedge clk);
    chk("mr.after", 64'(b8.out_valid), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
